// File: rtl/tt_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tt_pkg
// Brief   : Shared types and helpers for the truth-table sweeper.
//           State encoding, the legal input-count ceiling and a row-count
//           helper used to size masks and row indices.
// Revision: 1.0 - initial release
// ============================================================================
package tt_pkg;

   // Largest supported number of function inputs (64-row masks).
   localparam int MAX_N_IN = 6;

   // Sweeper control states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } tt_state_e;

   // Number of truth-table rows for an n-input function.
   function automatic int rows_of(input int n);
      return 1 << n;
   endfunction

endpackage : tt_pkg
`default_nettype wire

// File: rtl/tt_sweeper_if.sv
`default_nettype none
// ============================================================================
// Module  : tt_sweeper_if
// Brief   : Control/result bundle between a sweep controller (master) and the
//           truth-table sweeper (slave). Optional checker signals exist only
//           when TT_CHECK_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
interface tt_sweeper_if #(
   parameter int N_IN = 4
);
   import tt_pkg::*;

   localparam int ROWS = rows_of(N_IN);

   logic            start;
   logic            abort;
   logic [ROWS-1:0] func_mask;
   logic            busy;
   logic            done;
   logic            out_valid;
   logic            out_ready;
   logic [N_IN-1:0] out_idx;
   logic            out_val;
   logic [N_IN:0]   ones_count;
`ifdef TT_CHECK_EN
   logic [ROWS-1:0] exp_mask;
   logic            mismatch;
   logic [N_IN-1:0] first_bad_idx;
`endif

   // Controller / consumer side.
   modport master (
      output start, abort, func_mask, out_ready,
`ifdef TT_CHECK_EN
      output exp_mask,
      input  mismatch, first_bad_idx,
`endif
      input  busy, done, out_valid, out_idx, out_val, ones_count
   );

   // Sweeper side.
   modport slave (
      input  start, abort, func_mask, out_ready,
`ifdef TT_CHECK_EN
      input  exp_mask,
      output mismatch, first_bad_idx,
`endif
      output busy, done, out_valid, out_idx, out_val, ones_count
   );

endinterface : tt_sweeper_if
`default_nettype wire

// File: rtl/tt_row_counter.sv
`default_nettype none
// ============================================================================
// Module  : tt_row_counter
// Brief   : Row index register for the sweeper. Clears to row 0, advances on
//           inc and saturates at the last row (never wraps).
// Revision: 1.0 - initial release
// ============================================================================
module tt_row_counter #(
   parameter int N_IN = 4
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   input  wire logic            clr_i,
   input  wire logic            inc_i,
   output logic [N_IN-1:0]      idx_o,
   output logic                 last_o
);

   logic [N_IN-1:0] idx_q;

   // Row index: clear wins over increment; the last row is terminal.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else if (clr_i) begin
         idx_q <= '0;
      end else if (inc_i && !last_o) begin
         idx_q <= idx_q + 1'b1;
      end
   end

   assign idx_o  = idx_q;
   assign last_o = &idx_q;

endmodule : tt_row_counter
`default_nettype wire

// File: rtl/tt_sweeper.sv
`default_nettype none
// ============================================================================
// Module  : tt_sweeper
// Brief   : Sequential truth-table engine. Captures a minterm mask on start and
//           streams every row (index, value) over a valid/ready handshake,
//           counting accepted true rows. Optional expected-mask checker is
//           compiled in when the macro TT_CHECK_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module tt_sweeper
   import tt_pkg::*;
#(
   parameter int N_IN = 4
) (
   input wire logic     clk,
   input wire logic     rst_n,
   tt_sweeper_if.slave  bus
);

   localparam int ROWS = rows_of(N_IN);

   tt_state_e       state_q, state_d;
   logic [ROWS-1:0] mask_q;
   logic [N_IN:0]   ones_q;

   logic [N_IN-1:0] idx;
   logic            idx_last;
   logic            start_acc;
   logic            in_run;
   logic            handshake;
   logic            row_val;

   assign start_acc = (state_q == IDLE) && bus.start;
   assign in_run    = (state_q == RUN);
   // Abort takes priority: an aborted cycle never counts as a handshake.
   assign handshake = in_run && bus.out_ready && !bus.abort;
   assign row_val   = mask_q[idx];

   tt_row_counter #(
      .N_IN (N_IN)
   ) u_row_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (start_acc),
      .inc_i  (handshake),
      .idx_o  (idx),
      .last_o (idx_last)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: DONE lasts exactly one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN: begin
            if (bus.abort)                  state_d = IDLE;
            else if (handshake && idx_last) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Mask capture and running count of accepted true rows.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mask_q <= '0;
         ones_q <= '0;
      end else if (start_acc) begin
         mask_q <= bus.func_mask;
         ones_q <= '0;
      end else if (handshake) begin
         ones_q <= ones_q + {{N_IN{1'b0}}, row_val};
      end
   end

   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = (state_q == DONE);
   assign bus.out_valid  = in_run;
   assign bus.out_idx    = idx;
   assign bus.out_val    = in_run && row_val;
   assign bus.ones_count = ones_q;

`ifdef TT_CHECK_EN
   logic [ROWS-1:0] exp_q;
   logic            mismatch_q;
   logic [N_IN-1:0] first_bad_q;

   // Expected-mask checker: sticky flag and index of the first bad row.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exp_q       <= '0;
         mismatch_q  <= 1'b0;
         first_bad_q <= '0;
      end else if (start_acc) begin
         exp_q       <= bus.exp_mask;
         mismatch_q  <= 1'b0;
         first_bad_q <= '0;
      end else if (handshake && (row_val != exp_q[idx])) begin
         mismatch_q <= 1'b1;
         if (!mismatch_q) first_bad_q <= idx;
      end
   end

   assign bus.mismatch      = mismatch_q;
   assign bus.first_bad_idx = first_bad_q;
`endif

endmodule : tt_sweeper
`default_nettype wire

// File: tb/tb_tt_sweeper.sv
`default_nettype none
// ============================================================================
// Module  : tb_tt_sweeper
// Brief   : Directed self-checking bench for tt_sweeper (3- and 4-input builds).
// Revision: 1.0 - initial release
// ============================================================================
module tb_tt_sweeper;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   done_cnt4;

   tt_sweeper_if #(.N_IN(3)) bus3 ();
   tt_sweeper_if #(.N_IN(4)) bus4 ();

   tt_sweeper #(.N_IN(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
   tt_sweeper #(.N_IN(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count done pulses of the 4-input instance between edges.
   initial done_cnt4 = 0;
   always @(negedge clk) if (bus4.done) done_cnt4 = done_cnt4 + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int ev3 [8]  = '{0,1,0,1,1,1,0,0};
   int ev4 [16] = '{0,1,0,1,1,1,0,0,1,1,1,1,0,0,0,0};
   int snap;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n = 1'b0;
      bus3.start = 1'b0; bus3.abort = 1'b0; bus3.func_mask = '0; bus3.out_ready = 1'b0;
      bus4.start = 1'b0; bus4.abort = 1'b0; bus4.func_mask = '0; bus4.out_ready = 1'b0;
`ifdef TT_CHECK_EN
      bus3.exp_mask = '0;
      bus4.exp_mask = '0;
`endif
      step(); step();
      rst_n = 1'b1;

      // Reset state
      check("rst_busy",  32'(bus3.busy), 0);
      check("rst_valid", 32'(bus3.out_valid), 0);
      check("rst_done",  32'(bus3.done), 0);
      check("rst_ones",  32'(bus3.ones_count), 0);
      check("rst_idx",   32'(bus3.out_idx), 0);
      check("rst_val",   32'(bus3.out_val), 0);

      // 3-input sweep, ready held high, mask 8'h3A
      bus3.func_mask = 8'h3A;
      bus3.out_ready = 1'b1;
      bus3.start = 1'b1;
`ifdef TT_CHECK_EN
      bus3.exp_mask = 8'h3B;
`endif
      step();                           // cycle 1 after start
      bus3.start = 1'b0;
      bus3.func_mask = 8'h00;           // must not affect captured mask
      for (int k = 0; k < 8; k++) begin
         check("s3_valid", 32'(bus3.out_valid), 1);
         check("s3_idx",   32'(bus3.out_idx), 32'(k));
         check("s3_val",   32'(bus3.out_val), 32'(ev3[k]));
         check("s3_nodone", 32'(bus3.done), 0);
         step();
      end
      check("s3_done",  32'(bus3.done), 1);   // cycle 9 after start
      check("s3_ones",  32'(bus3.ones_count), 4);
      check("s3_dvld",  32'(bus3.out_valid), 0);
      check("s3_dbusy", 32'(bus3.busy), 1);
`ifdef TT_CHECK_EN
      check("chk_mis",  32'(bus3.mismatch), 1);
      check("chk_bad",  32'(bus3.first_bad_idx), 0);
`endif
      step();
      check("s3_idle_busy", 32'(bus3.busy), 0);
      check("s3_idle_done", 32'(bus3.done), 0);
      check("s3_hold_ones", 32'(bus3.ones_count), 4);

      // 4-input sweep, ready toggling, restart attempts during RUN and DONE
      snap = done_cnt4;
      bus4.func_mask = 16'h0F3A;
      bus4.start = 1'b1;
      step();
      bus4.start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         bus4.out_ready = 1'b0;
         if (k == 5) begin
            bus4.start = 1'b1;
            bus4.func_mask = 16'hFFFF;
         end
         check("s4_idx",  32'(bus4.out_idx), 32'(k));
         check("s4_val",  32'(bus4.out_val), 32'(ev4[k]));
         step();
         bus4.start = 1'b0;
         check("s4_hold_idx", 32'(bus4.out_idx), 32'(k));
         check("s4_hold_vld", 32'(bus4.out_valid), 1);
         bus4.out_ready = 1'b1;
         step();
      end
      bus4.out_ready = 1'b0;
      check("s4_done", 32'(bus4.done), 1);
      check("s4_ones", 32'(bus4.ones_count), 8);
      bus4.start = 1'b1;                // start in DONE cycle: ignored
      step();
      bus4.start = 1'b0;
      check("s4_nostart_busy", 32'(bus4.busy), 0);
      check("s4_nostart_vld",  32'(bus4.out_valid), 0);
      check("s4_ones_hold",    32'(bus4.ones_count), 8);
      step();
      check("s4_idle_busy", 32'(bus4.busy), 0);
      check("s4_one_done",  32'(done_cnt4 - snap), 1);

      // Abort at idx 5 with ready high
      snap = done_cnt4;
      bus4.func_mask = 16'hFFFF;
      bus4.out_ready = 1'b1;
      bus4.start = 1'b1;
      step();
      bus4.start = 1'b0;
      for (int k = 0; k < 5; k++) step();
      check("ab_idx",  32'(bus4.out_idx), 5);
      check("ab_ones_pre", 32'(bus4.ones_count), 5);
      bus4.abort = 1'b1;
      step();
      bus4.abort = 1'b0;
      check("ab_vld",  32'(bus4.out_valid), 0);
      check("ab_busy", 32'(bus4.busy), 0);
      check("ab_ones", 32'(bus4.ones_count), 5);
      step();
      check("ab_busy2", 32'(bus4.busy), 0);
      check("ab_nodone", 32'(done_cnt4 - snap), 0);

      // Synchronous reset mid-sweep at idx 3
      bus4.start = 1'b1;
      step();
      bus4.start = 1'b0;
      for (int k = 0; k < 3; k++) step();
      check("rs_idx_pre", 32'(bus4.out_idx), 3);
      snap = done_cnt4;
      rst_n = 1'b0;
      step();
      check("rs_busy", 32'(bus4.busy), 0);
      check("rs_vld",  32'(bus4.out_valid), 0);
      check("rs_idx",  32'(bus4.out_idx), 0);
      check("rs_val",  32'(bus4.out_val), 0);
      check("rs_ones", 32'(bus4.ones_count), 0);
      check("rs_done", 32'(bus4.done), 0);
      rst_n = 1'b1;
      step();
      check("rs_idle", 32'(bus4.busy), 0);
      check("rs_nodone", 32'(done_cnt4 - snap), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_tt_sweeper
`default_nettype wire
